// File: rtl/uart_rx_bit_timer_if.sv
// ============================================================================
// Module   : uart_rx_bit_timer_if
// Purpose  : Control/status bundle between the RX FSM and the UART RX bit timer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_rx_bit_timer_if #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
);
    logic                      enable;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [BIT_CNT_WIDTH-1:0]  frame_bits;
    logic                      resync;

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic                      bit_tick;
    logic                      sample_stb;
    logic [1:0]                sample_idx;
    logic                      frame_done;
    logic                      busy;

    // RX FSM side: drives the controls, observes timing status.
    modport master (
        output enable, prescale, frame_bits, resync,
        input  edge_cnt, bit_cnt, bit_tick, sample_stb, sample_idx, frame_done, busy
    );

    // Timer side.
    modport slave (
        input  enable, prescale, frame_bits, resync,
        output edge_cnt, bit_cnt, bit_tick, sample_stb, sample_idx, frame_done, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_bit_timer.sv
// ============================================================================
// Module   : uart_rx_bit_timer
// Purpose  : Oversampling edge / frame bit counter with mid-bit sample strobes.
//            Optional drift correction on line transitions: UART_RX_RESYNC_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_bit_timer #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_rx_bit_timer_if.slave bus
);
    localparam logic [PRESCALE_WIDTH-1:0] c_min_psc = PRESCALE_WIDTH'(4);
    localparam logic [BIT_CNT_WIDTH-1:0]  c_min_fb  = BIT_CNT_WIDTH'(1);

    logic                      r_busy;
    logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
    logic [PRESCALE_WIDTH-1:0] r_psc;
    logic [BIT_CNT_WIDTH-1:0]  r_bit_cnt;
    logic [BIT_CNT_WIDTH-1:0]  r_fb;

    logic                      w_run;
    logic [PRESCALE_WIDTH-1:0] w_mid;
    logic [PRESCALE_WIDTH-1:0] w_last_edge;
    logic                      w_nat_tick;
    logic                      w_tick;
    logic                      w_last_bit;
    logic                      w_done;
    logic                      w_rs_late;
    logic                      w_rs_early;
    logic                      w_stb;
    logic [1:0]                w_idx;

    // Counting is only live once a frame has been captured and enable holds.
    assign w_run       = bus.enable & r_busy;
    assign w_mid       = r_psc >> 1;
    assign w_last_edge = r_psc - PRESCALE_WIDTH'(1);
    assign w_nat_tick  = w_run & (r_edge_cnt == w_last_edge);
    assign w_last_bit  = (r_bit_cnt == (r_fb - BIT_CNT_WIDTH'(1)));

`ifdef UART_RX_RESYNC_EN
    // A natural tick wins over a late-half resync so the bit counter never double-steps.
    assign w_rs_late  = w_run & bus.resync & ~w_nat_tick &
                        (r_edge_cnt >= (w_mid + PRESCALE_WIDTH'(2)));
    assign w_rs_early = w_run & bus.resync &
                        (r_edge_cnt <= (w_mid - PRESCALE_WIDTH'(2)));
`else
    logic w_unused_resync;
    assign w_unused_resync = bus.resync;
    assign w_rs_late       = 1'b0;
    assign w_rs_early      = 1'b0;
`endif

    assign w_tick = w_nat_tick | w_rs_late;
    assign w_done = w_tick & w_last_bit;

    always_comb begin
        w_stb = 1'b0;
        w_idx = 2'd0;
        if (w_run) begin
            if (r_edge_cnt == (w_mid - PRESCALE_WIDTH'(1))) begin
                w_stb = 1'b1;
                w_idx = 2'd0;
            end else if (r_edge_cnt == w_mid) begin
                w_stb = 1'b1;
                w_idx = 2'd1;
            end else if (r_edge_cnt == (w_mid + PRESCALE_WIDTH'(1))) begin
                w_stb = 1'b1;
                w_idx = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_psc      <= '0;
            r_fb       <= '0;
        end else if (!bus.enable) begin
            r_busy     <= 1'b0;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (!r_busy) begin
            // Capture cycle is edge 0 of bit 0; settings are frozen for the frame.
            r_busy     <= 1'b1;
            r_psc      <= (bus.prescale < c_min_psc) ? c_min_psc : bus.prescale;
            r_fb       <= (bus.frame_bits == '0) ? c_min_fb : bus.frame_bits;
            r_edge_cnt <= PRESCALE_WIDTH'(1);
            r_bit_cnt  <= '0;
        end else if (w_tick) begin
            r_edge_cnt <= '0;
            if (w_last_bit) begin
                r_bit_cnt <= '0;
                r_busy    <= 1'b0;
            end else begin
                r_bit_cnt <= r_bit_cnt + BIT_CNT_WIDTH'(1);
            end
        end else if (w_rs_early) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + PRESCALE_WIDTH'(1);
        end
    end

    // Reset forces every output low within the reset cycle itself.
    assign bus.edge_cnt   = rst ? '0 : r_edge_cnt;
    assign bus.bit_cnt    = rst ? '0 : r_bit_cnt;
    assign bus.bit_tick   = ~rst & w_tick;
    assign bus.sample_stb = ~rst & w_stb;
    assign bus.sample_idx = rst ? 2'd0 : w_idx;
    assign bus.frame_done = ~rst & w_done;
    assign bus.busy       = ~rst & r_busy;

endmodule

`default_nettype wire
